// File: rtl/framebuffer_writeback_buffer.sv
//------------------------------------------------------------------------------
// framebuffer_writeback_buffer
// Tile buffer: strobed fragment writes, 1-cycle write-first read port,
// whole-tile clear engine and frame completion signalling.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module framebuffer_writeback_buffer #(
    parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int DEPTH_WIDTH             = 16,
    parameter int STENCIL_WIDTH           = 4,
    parameter int SUB_PIXEL_WIDTH         = 8
) (
    input  logic                               aclk,
    input  logic                               reset,
    input  logic                               s_frag_tvalid,
    output logic                               s_frag_tready,
    input  logic                               s_frag_tlast,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] s_frag_taddr,
    input  logic [4*SUB_PIXEL_WIDTH-1:0]       s_frag_color_tdata,
    input  logic                               s_frag_color_tstrb,
    input  logic [DEPTH_WIDTH-1:0]             s_frag_depth_tdata,
    input  logic                               s_frag_depth_tstrb,
    input  logic [STENCIL_WIDTH-1:0]           s_frag_stencil_tdata,
    input  logic                               s_frag_stencil_tstrb,
    input  logic                               rd_ce,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] rd_addr,
    output logic [4*SUB_PIXEL_WIDTH-1:0]       rd_color,
    output logic [DEPTH_WIDTH-1:0]             rd_depth,
    output logic [STENCIL_WIDTH-1:0]           rd_stencil,
    input  logic                               clear_start,
    input  logic [4*SUB_PIXEL_WIDTH-1:0]       clear_color,
    input  logic [DEPTH_WIDTH-1:0]             clear_depth,
    input  logic [STENCIL_WIDTH-1:0]           clear_stencil,
    input  logic                               clear_color_en,
    input  logic                               clear_depth_en,
    input  logic                               clear_stencil_en,
    output logic                               busy,
    output logic                               frame_done,
    output logic [31:0]                        frag_count
);

    localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;
    localparam int NUM_ENTRIES = 1 << FRAMEBUFFER_INDEX_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]                         state_q, state_d;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [PIXEL_WIDTH-1:0]             clr_color_q, clr_color_d;
    logic [DEPTH_WIDTH-1:0]             clr_depth_q, clr_depth_d;
    logic [STENCIL_WIDTH-1:0]           clr_stencil_q, clr_stencil_d;
    logic                               clr_color_en_q, clr_color_en_d;
    logic                               clr_depth_en_q, clr_depth_en_d;
    logic                               clr_stencil_en_q, clr_stencil_en_d;
    logic [31:0]                        frag_count_q, frag_count_d;
    logic                               frame_done_q, frame_done_d;
    logic [PIXEL_WIDTH-1:0]             rd_color_q;
    logic [DEPTH_WIDTH-1:0]             rd_depth_q;
    logic [STENCIL_WIDTH-1:0]           rd_stencil_q;

    logic                               w_in_clear;
    logic                               w_accept;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] w_wr_addr;
    logic                               w_we_color, w_we_depth, w_we_stencil;
    logic [PIXEL_WIDTH-1:0]             w_wd_color;
    logic [DEPTH_WIDTH-1:0]             w_wd_depth;
    logic [STENCIL_WIDTH-1:0]           w_wd_stencil;
    logic                               w_fwd;

    logic [PIXEL_WIDTH-1:0]   color_mem   [NUM_ENTRIES];
    logic [DEPTH_WIDTH-1:0]   depth_mem   [NUM_ENTRIES];
    logic [STENCIL_WIDTH-1:0] stencil_mem [NUM_ENTRIES];

    assign w_in_clear    = (state_q == ST_CLEAR);
    assign s_frag_tready = (state_q == ST_IDLE);
    assign w_accept      = s_frag_tvalid & s_frag_tready;

    // The clear engine owns the single write port while active
    assign w_wr_addr    = w_in_clear ? clr_addr_q : s_frag_taddr;
    assign w_we_color   = w_in_clear ? clr_color_en_q   : (w_accept & s_frag_color_tstrb);
    assign w_we_depth   = w_in_clear ? clr_depth_en_q   : (w_accept & s_frag_depth_tstrb);
    assign w_we_stencil = w_in_clear ? clr_stencil_en_q : (w_accept & s_frag_stencil_tstrb);
    assign w_wd_color   = w_in_clear ? clr_color_q   : s_frag_color_tdata;
    assign w_wd_depth   = w_in_clear ? clr_depth_q   : s_frag_depth_tdata;
    assign w_wd_stencil = w_in_clear ? clr_stencil_q : s_frag_stencil_tdata;
    assign w_fwd        = (w_wr_addr == rd_addr);

    always_comb begin
        state_d          = state_q;
        clr_addr_d       = clr_addr_q;
        clr_color_d      = clr_color_q;
        clr_depth_d      = clr_depth_q;
        clr_stencil_d    = clr_stencil_q;
        clr_color_en_d   = clr_color_en_q;
        clr_depth_en_d   = clr_depth_en_q;
        clr_stencil_en_d = clr_stencil_en_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d          = ST_CLEAR;
                    clr_addr_d       = '0;
                    clr_color_d      = clear_color;
                    clr_depth_d      = clear_depth;
                    clr_stencil_d    = clear_stencil;
                    clr_color_en_d   = clear_color_en;
                    clr_depth_en_d   = clear_depth_en;
                    clr_stencil_en_d = clear_stencil_en;
                end
            end
            default: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign frag_count_d = frag_count_q + {31'd0, w_accept};
    assign frame_done_d = w_accept & s_frag_tlast;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            clr_addr_q       <= '0;
            clr_color_q      <= '0;
            clr_depth_q      <= '0;
            clr_stencil_q    <= '0;
            clr_color_en_q   <= 1'b0;
            clr_depth_en_q   <= 1'b0;
            clr_stencil_en_q <= 1'b0;
            frag_count_q     <= '0;
            frame_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            clr_addr_q       <= clr_addr_d;
            clr_color_q      <= clr_color_d;
            clr_depth_q      <= clr_depth_d;
            clr_stencil_q    <= clr_stencil_d;
            clr_color_en_q   <= clr_color_en_d;
            clr_depth_en_q   <= clr_depth_en_d;
            clr_stencil_en_q <= clr_stencil_en_d;
            frag_count_q     <= frag_count_d;
            frame_done_q     <= frame_done_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we_color)   color_mem[w_wr_addr]   <= w_wd_color;
        if (w_we_depth)   depth_mem[w_wr_addr]   <= w_wd_depth;
        if (w_we_stencil) stencil_mem[w_wr_addr] <= w_wd_stencil;
    end

    // Write-first: a plane being written this cycle at rd_addr returns the new word
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            rd_color_q   <= '0;
            rd_depth_q   <= '0;
            rd_stencil_q <= '0;
        end else if (rd_ce) begin
            rd_color_q   <= (w_we_color   && w_fwd) ? w_wd_color   : color_mem[rd_addr];
            rd_depth_q   <= (w_we_depth   && w_fwd) ? w_wd_depth   : depth_mem[rd_addr];
            rd_stencil_q <= (w_we_stencil && w_fwd) ? w_wd_stencil : stencil_mem[rd_addr];
        end
    end

    assign rd_color   = rd_color_q;
    assign rd_depth   = rd_depth_q;
    assign rd_stencil = rd_stencil_q;
    assign busy       = w_in_clear;
    assign frame_done = frame_done_q;
    assign frag_count = frag_count_q;

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_writeback_buffer.sv
//------------------------------------------------------------------------------
// tb_framebuffer_writeback_buffer
// Randomized and directed bench against an array-based reference of the tile.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_framebuffer_writeback_buffer;

    localparam int IW = 4;
    localparam int N  = 1 << IW;

    logic          aclk = 1'b0;
    logic          reset;
    logic          s_frag_tvalid, s_frag_tready, s_frag_tlast;
    logic [IW-1:0] s_frag_taddr;
    logic [31:0]   s_frag_color_tdata;
    logic          s_frag_color_tstrb;
    logic [15:0]   s_frag_depth_tdata;
    logic          s_frag_depth_tstrb;
    logic [3:0]    s_frag_stencil_tdata;
    logic          s_frag_stencil_tstrb;
    logic          rd_ce;
    logic [IW-1:0] rd_addr;
    logic [31:0]   rd_color;
    logic [15:0]   rd_depth;
    logic [3:0]    rd_stencil;
    logic          clear_start;
    logic [31:0]   clear_color;
    logic [15:0]   clear_depth;
    logic [3:0]    clear_stencil;
    logic          clear_color_en, clear_depth_en, clear_stencil_en;
    logic          busy, frame_done;
    logic [31:0]   frag_count;

    framebuffer_writeback_buffer #(
        .FRAMEBUFFER_INDEX_WIDTH(IW),
        .DEPTH_WIDTH(16),
        .STENCIL_WIDTH(4),
        .SUB_PIXEL_WIDTH(8)
    ) dut (
        .aclk(aclk), .reset(reset),
        .s_frag_tvalid(s_frag_tvalid), .s_frag_tready(s_frag_tready),
        .s_frag_tlast(s_frag_tlast), .s_frag_taddr(s_frag_taddr),
        .s_frag_color_tdata(s_frag_color_tdata), .s_frag_color_tstrb(s_frag_color_tstrb),
        .s_frag_depth_tdata(s_frag_depth_tdata), .s_frag_depth_tstrb(s_frag_depth_tstrb),
        .s_frag_stencil_tdata(s_frag_stencil_tdata), .s_frag_stencil_tstrb(s_frag_stencil_tstrb),
        .rd_ce(rd_ce), .rd_addr(rd_addr),
        .rd_color(rd_color), .rd_depth(rd_depth), .rd_stencil(rd_stencil),
        .clear_start(clear_start), .clear_color(clear_color),
        .clear_depth(clear_depth), .clear_stencil(clear_stencil),
        .clear_color_en(clear_color_en), .clear_depth_en(clear_depth_en),
        .clear_stencil_en(clear_stencil_en),
        .busy(busy), .frame_done(frame_done), .frag_count(frag_count)
    );

    always #5 aclk = ~aclk;

    // Reference tile contents and observable state
    logic [31:0] m_color   [N];
    logic [15:0] m_depth   [N];
    logic [3:0]  m_stencil [N];
    int          m_clr_pos;
    logic [31:0] m_cc;
    logic [15:0] m_cd;
    logic [3:0]  m_cs;
    logic        m_ce, m_de, m_se;
    logic [31:0] m_cnt;
    logic        m_done;
    logic [31:0] e_color;
    logic [15:0] e_depth;
    logic [3:0]  e_stencil;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic idle_inputs();
        s_frag_tvalid = 0; s_frag_tlast = 0; s_frag_taddr = '0;
        s_frag_color_tdata = '0; s_frag_depth_tdata = '0; s_frag_stencil_tdata = '0;
        s_frag_color_tstrb = 0; s_frag_depth_tstrb = 0; s_frag_stencil_tstrb = 0;
        rd_ce = 0; rd_addr = '0; clear_start = 0;
        clear_color = '0; clear_depth = '0; clear_stencil = '0;
        clear_color_en = 0; clear_depth_en = 0; clear_stencil_en = 0;
    endtask

    task automatic check_outputs();
        check_value("rd_color",   {32'd0, rd_color},   {32'd0, e_color});
        check_value("rd_depth",   {48'd0, rd_depth},   {48'd0, e_depth});
        check_value("rd_stencil", {60'd0, rd_stencil}, {60'd0, e_stencil});
        check_value("busy",       {63'd0, busy},       {63'd0, m_clr_pos >= 0});
        check_value("tready",     {63'd0, s_frag_tready}, {63'd0, m_clr_pos < 0});
        check_value("frame_done", {63'd0, frame_done}, {63'd0, m_done});
        check_value("frag_count", {32'd0, frag_count}, {32'd0, m_cnt});
    endtask

    // Apply current inputs to the model, clock once, compare
    task automatic step();
        logic acc;
        acc = s_frag_tvalid && (m_clr_pos < 0);
        if (m_clr_pos >= 0) begin
            if (m_ce) m_color[m_clr_pos]   = m_cc;
            if (m_de) m_depth[m_clr_pos]   = m_cd;
            if (m_se) m_stencil[m_clr_pos] = m_cs;
        end else if (acc) begin
            if (s_frag_color_tstrb)   m_color[s_frag_taddr]   = s_frag_color_tdata;
            if (s_frag_depth_tstrb)   m_depth[s_frag_taddr]   = s_frag_depth_tdata;
            if (s_frag_stencil_tstrb) m_stencil[s_frag_taddr] = s_frag_stencil_tdata;
            m_cnt = m_cnt + 1;
        end
        if (rd_ce) begin
            e_color = m_color[rd_addr]; e_depth = m_depth[rd_addr]; e_stencil = m_stencil[rd_addr];
        end
        m_done = acc && s_frag_tlast;
        if (m_clr_pos >= 0) m_clr_pos = (m_clr_pos == N - 1) ? -1 : m_clr_pos + 1;
        else if (clear_start) begin
            m_cc = clear_color; m_cd = clear_depth; m_cs = clear_stencil;
            m_ce = clear_color_en; m_de = clear_depth_en; m_se = clear_stencil_en;
            m_clr_pos = 0;
        end
        @(posedge aclk);
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        m_clr_pos = -1; m_cnt = 0; m_done = 0;
        e_color = 0; e_depth = 0; e_stencil = 0;
    endtask

    task automatic write_beat(input int a, input logic [31:0] c, input logic [15:0] d,
                              input logic [3:0] s, input logic [2:0] strb, input logic last);
        s_frag_tvalid = 1; s_frag_taddr = IW'(a); s_frag_tlast = last;
        s_frag_color_tdata = c; s_frag_depth_tdata = d; s_frag_stencil_tdata = s;
        {s_frag_color_tstrb, s_frag_depth_tstrb, s_frag_stencil_tstrb} = strb;
    endtask

    task automatic run_clear(input logic [31:0] c, input logic [15:0] d, input logic [3:0] s,
                             input logic [2:0] en);
        int busy_cycles;
        idle_inputs();
        clear_start = 1; clear_color = c; clear_depth = d; clear_stencil = s;
        {clear_color_en, clear_depth_en, clear_stencil_en} = en;
        step();
        idle_inputs();
        busy_cycles = 0;
        for (int i = 0; i < N + 4 && busy; i++) begin
            busy_cycles++;
            step();
        end
        check_value("clear_busy_cycles", 64'(busy_cycles), 64'(N));
    endtask

    task automatic readback_all();
        for (int a = 0; a < N; a++) begin
            idle_inputs(); rd_ce = 1; rd_addr = IW'(a);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            m_color[i] = 'x; m_depth[i] = 'x; m_stencil[i] = 'x;
        end
        repeat (3) @(posedge aclk);
        #1;
        check_outputs();
        @(negedge aclk); reset = 0;
        @(posedge aclk); #1;

        // Establish known tile contents
        run_clear(32'hFFFF_FFFF, 16'h1234, 4'h5, 3'b111);

        // Full-strobe write then read back
        write_beat(5, 32'h1122_3344, 16'hABCD, 4'h3, 3'b111, 0);
        step();
        idle_inputs(); rd_ce = 1; rd_addr = 5;
        step();
        check_value("t1_color", {32'd0, rd_color}, 64'h1122_3344);
        check_value("t1_depth", {48'd0, rd_depth}, 64'hABCD);
        check_value("t1_count", {32'd0, frag_count}, 64'd1);

        // Depth-only write forwarded to a same-cycle read
        write_beat(7, 32'h0, 16'h0042, 4'h0, 3'b010, 0);
        rd_ce = 1; rd_addr = 7;
        step();
        check_value("t2_fwd_depth", {48'd0, rd_depth}, 64'h0042);
        check_value("t2_old_color", {32'd0, rd_color}, 64'hFFFF_FFFF);

        // tlast beat in the same cycle as a depth-only clear
        idle_inputs();
        write_beat(3, 32'hCAFE_F00D, 16'h7777, 4'h9, 3'b111, 1);
        clear_start = 1; clear_depth = 16'hFFFF; clear_depth_en = 1;
        step();
        check_value("t4_frame_done", {63'd0, frame_done}, 64'd1);
        idle_inputs();
        begin
            int bc;
            bc = 0;
            for (int i = 0; i < N + 4 && busy; i++) begin
                bc++;
                step();
            end
            check_value("t4_busy_cycles", 64'(bc), 64'(N));
        end
        readback_all();
        idle_inputs(); rd_ce = 1; rd_addr = 3;
        step();
        check_value("t4_beat_color_kept", {32'd0, rd_color}, 64'hCAFE_F00D);
        check_value("t4_depth_cleared", {48'd0, rd_depth}, 64'hFFFF);

        // Reset asserted while the clear is at address 8
        idle_inputs();
        clear_start = 1; clear_color = 32'h5A5A_5A5A; clear_color_en = 1;
        step();
        idle_inputs();
        while (m_clr_pos != 8) step();
        reset = 1;
        #1;
        model_reset();
        check_outputs();
        @(negedge aclk); reset = 0;
        @(posedge aclk); #1;
        check_value("t5_tready", {63'd0, s_frag_tready}, 64'd1);
        readback_all();

        // rd_ce low holds the read data across address changes
        idle_inputs(); rd_ce = 1; rd_addr = 5;
        step();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); rd_ce = 0; rd_addr = IW'($urandom);
            step();
        end

        // Counter wrap
        idle_inputs();
        write_beat(1, 32'h0, 16'h0, 4'h0, 3'b000, 0);
        force dut.frag_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.frag_count_q;
        m_cnt = 32'hFFFF_FFFF;
        step();
        check_value("t6_count_wrap", {32'd0, frag_count}, 64'd0);

        // Randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            write_beat(int'($urandom_range(0, N - 1)), $urandom, 16'($urandom), 4'($urandom),
                       3'($urandom), 1'($urandom_range(0, 7) == 0));
            s_frag_tvalid = 1'($urandom);
            rd_ce = 1'($urandom);
            rd_addr = IW'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                clear_start = 1;
                clear_color = $urandom; clear_depth = 16'($urandom); clear_stencil = 4'($urandom);
                {clear_color_en, clear_depth_en, clear_stencil_en} = 3'($urandom);
            end
            step();
        end
        idle_inputs();
        while (m_clr_pos >= 0) step();
        readback_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
